md_ctrl: RTL and testbench

- Multiply/divide sequencer for the 5-stage pipelined MIPS core; sits beside the E-stage ALU.
- Accepts mult/multu/div/divu/mthi/mtlo from E and owns the HI/LO registers.
- Models fixed multi-cycle latency with a busy counter and raises the D-stage stall so that any following HI/LO-touching instruction waits.
- Serves mfhi/mflo reads to the E-stage result mux.

---
 rtl/md_defs.sv | 30 +++
 rtl/md_calc.sv | 54 +++++
 rtl/md_ctrl.sv | 103 ++++++++++
 tb/tb_md_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_defs.sv
// Shared constants for the multiply/divide sequencer: E-stage op codes,
// HI/LO read selects, FSM state encoding and op classification helpers.
package md_defs;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;

  localparam logic [1:0] RD_NONE = 2'd0;
  localparam logic [1:0] RD_HI   = 2'd1;
  localparam logic [1:0] RD_LO   = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  function automatic logic is_start(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational 64-bit result generator for mult/multu/div/divu.
// Signed division works on magnitudes so the INT_MIN / -1 case needs no special path.
module md_calc
  import md_defs::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_n_o,
  output logic [31:0] lo_n_o,
  output logic        div0_o
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] a_mag, b_mag, b_safe, bm_safe;
  logic        [31:0] q_mag, r_mag, q_u, r_u;
  logic               b_nz;

  always_comb begin
    prod_s  = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    prod_u  = {32'd0, a_i} * {32'd0, b_i};
    b_nz    = (b_i != 32'd0);
    a_mag   = a_i[31] ? (~a_i + 32'd1) : a_i;
    b_mag   = b_i[31] ? (~b_i + 32'd1) : b_i;
    b_safe  = b_nz ? b_i : 32'd1;
    bm_safe = b_nz ? b_mag : 32'd1;
    q_mag   = a_mag / bm_safe;
    r_mag   = a_mag % bm_safe;
    q_u     = a_i / b_safe;
    r_u     = a_i % b_safe;

    hi_n_o = 32'd0;
    lo_n_o = 32'd0;
    div0_o = 1'b0;
    case (op_i)
      MD_MULT:  {hi_n_o, lo_n_o} = prod_s;
      MD_MULTU: {hi_n_o, lo_n_o} = prod_u;
      MD_DIV: begin
        // Quotient truncates toward zero; remainder follows the dividend's sign.
        lo_n_o = (a_i[31] ^ b_i[31]) ? (~q_mag + 32'd1) : q_mag;
        hi_n_o = a_i[31] ? (~r_mag + 32'd1) : r_mag;
        div0_o = ~b_nz;
      end
      MD_DIVU: begin
        lo_n_o = q_u;
        hi_n_o = r_u;
        div0_o = ~b_nz;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer beside the E-stage ALU: owns HI/LO, models fixed
// op latency with a busy counter and requests D-stage stalls for HI/LO users.
module md_ctrl
  import md_defs::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  e_md_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic [1:0]  e_rd_sel,
  input  logic        d_uses_md,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] md_out
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  md_state_e   state_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] hi_n_q, lo_n_q;
  logic        div0_q;

  logic [31:0] calc_hi, calc_lo;
  logic        calc_div0;

  md_calc u_calc (
    .op_i   (e_md_op),
    .a_i    (e_rs),
    .b_i    (e_rt),
    .hi_n_o (calc_hi),
    .lo_n_o (calc_lo),
    .div0_o (calc_div0)
  );

  // Results are computed at issue and parked in hi_n/lo_n until the counter
  // expires, so reads during the busy window still see the old HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      hi_n_q  <= 32'd0;
      lo_n_q  <= 32'd0;
      div0_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (is_start(e_md_op)) begin
            hi_n_q  <= calc_hi;
            lo_n_q  <= calc_lo;
            div0_q  <= calc_div0;
            cnt_q   <= is_div(e_md_op) ? DIV_CNT : MULT_CNT;
            busy_q  <= 1'b1;
            state_q <= BUSY;
          end else if (e_md_op == MD_MTHI) begin
            hi_q <= e_rs;
          end else if (e_md_op == MD_MTLO) begin
            lo_q <= e_rs;
          end
        end
        BUSY: begin
          // A start arriving here is a protocol violation and is dropped.
          if (cnt_q == 4'd1) begin
            if (!div0_q) begin
              hi_q <= hi_n_q;
              lo_q <= lo_n_q;
            end
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    md_out = 32'd0;
    case (e_rd_sel)
      RD_HI:   md_out = hi_q;
      RD_LO:   md_out = lo_q;
      default: md_out = 32'd0;
    endcase
  end

  // The start term covers the cycle the op sits in E, before busy rises.
  assign stall_md = d_uses_md & (busy_q | is_start(e_md_op));
  assign busy     = busy_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: directed cases pinned with literal values,
// then randomized traffic compared every cycle against a cycle-count model.
module tb_md_ctrl;
  import md_defs::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  e_md_op;
  logic [31:0] e_rs, e_rt;
  logic [1:0]  e_rd_sel;
  logic        d_uses_md;
  logic        busy, stall_md;
  logic [31:0] md_out;

  always #5 clk = ~clk;

  md_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk       (clk),
    .reset     (reset),
    .e_md_op   (e_md_op),
    .e_rs      (e_rs),
    .e_rt      (e_rt),
    .e_rd_sel  (e_rd_sel),
    .d_uses_md (d_uses_md),
    .busy      (busy),
    .stall_md  (stall_md),
    .md_out    (md_out)
  );

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pending results wait in exp_q as {div0, hi, lo}; the model only knows
  // the issue cycle and the cycle whose closing edge commits.
  logic [64:0] exp_q[$];
  logic [31:0] m_hi, m_lo;
  bit          m_active    = 1'b0;
  bit          model_valid = 1'b0;
  longint      m_cyc       = 0;
  longint      m_commit_cyc;

  function automatic bit ref_start(input logic [3:0] op);
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  endfunction

  function automatic logic [64:0] ref_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     p;
    logic [64:0]     res;
    res = '0;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    case (op)
      MD_MULT: begin
        p = 64'(sa * sb);
        res = {1'b0, p};
      end
      MD_MULTU: begin
        p = ua * ub;
        res = {1'b0, p};
      end
      MD_DIV: begin
        if (b == 32'd0) res[64] = 1'b1;
        else begin
          q = sa / sb;
          r = sa - q * sb;
          res = {1'b0, r[31:0], q[31:0]};
        end
      end
      MD_DIVU: begin
        if (b == 32'd0) res[64] = 1'b1;
        else begin
          p[31:0]  = 32'(ua / ub);
          p[63:32] = 32'(ua - (ua / ub) * ub);
          res = {1'b0, p};
        end
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  always @(posedge clk) begin
    logic [64:0] r;
    if (reset) begin
      m_hi = 32'd0;
      m_lo = 32'd0;
      m_active = 1'b0;
      exp_q.delete();
    end else if (m_active) begin
      if (m_cyc == m_commit_cyc) begin
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL model_queue: got empty expected one pending result");
        end else begin
          r = exp_q.pop_front();
          if (!r[64]) {m_hi, m_lo} = r[63:0];
        end
        m_active = 1'b0;
      end
    end else if (ref_start(e_md_op)) begin
      exp_q.push_back(ref_calc(e_md_op, e_rs, e_rt));
      m_active = 1'b1;
      m_commit_cyc = m_cyc + ((e_md_op inside {MD_DIV, MD_DIVU}) ? DIV_N : MULT_N);
    end else if (e_md_op == MD_MTHI) begin
      m_hi = e_rs;
    end else if (e_md_op == MD_MTLO) begin
      m_lo = e_rs;
    end
    m_cyc++;
    model_valid = 1'b1;
  end

  always @(negedge clk) begin
    logic [31:0] exp_out;
    if (model_valid) begin
      exp_out = (e_rd_sel == 2'd1) ? m_hi : (e_rd_sel == 2'd2) ? m_lo : 32'd0;
      check("busy", {31'd0, busy}, {31'd0, m_active});
      check("stall_md", {31'd0, stall_md}, {31'd0, d_uses_md & (m_active | ref_start(e_md_op))});
      check("md_out", md_out, exp_out);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                      input logic [1:0] sel, input logic du, input logic rst);
    @(posedge clk);
    #1;
    e_md_op   = op;
    e_rs      = rs;
    e_rt      = rt;
    e_rd_sel  = sel;
    d_uses_md = du;
    reset     = rst;
    @(negedge clk);
  endtask

  task automatic idle_count_busy(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      step(MD_NONE, 32'd0, 32'd0, RD_NONE, 1'b0, 1'b0);
      if (busy) cnt++;
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int          cnt;
    logic [3:0]  op;
    logic [31:0] rs, rt;
    int          r;

    reset = 1'b1; e_md_op = MD_NONE; e_rs = '0; e_rt = '0; e_rd_sel = RD_NONE; d_uses_md = 1'b0;
    repeat (3) step(MD_NONE, 32'd0, 32'd0, RD_NONE, 1'b0, 1'b1);
    step(MD_NONE, 32'd0, 32'd0, RD_HI, 1'b0, 1'b0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", md_out, 32'd0);
    step(MD_NONE, 32'd0, 32'd0, RD_LO, 1'b0, 1'b0);
    check("reset_lo", md_out, 32'd0);

    // MULT -1 * 2
    step(MD_MULT, 32'hFFFF_FFFF, 32'd2, RD_NONE, 1'b0, 1'b0);
    idle_count_busy(7, cnt);
    check("mult_busy_cycles", cnt, 32'd5);
    step(MD_NONE, 32'd0, 32'd0, RD_LO, 1'b0, 1'b0);
    check("mult_lo", md_out, 32'hFFFF_FFFE);
    step(MD_NONE, 32'd0, 32'd0, RD_HI, 1'b0, 1'b0);
    check("mult_hi", md_out, 32'hFFFF_FFFF);

    // MULTU same operands
    step(MD_MULTU, 32'hFFFF_FFFF, 32'd2, RD_NONE, 1'b0, 1'b0);
    idle_count_busy(7, cnt);
    step(MD_NONE, 32'd0, 32'd0, RD_HI, 1'b0, 1'b0);
    check("multu_hi", md_out, 32'h0000_0001);
    step(MD_NONE, 32'd0, 32'd0, RD_LO, 1'b0, 1'b0);
    check("multu_lo", md_out, 32'hFFFF_FFFE);

    // DIV -7 / 2
    step(MD_DIV, 32'hFFFF_FFF9, 32'd2, RD_NONE, 1'b0, 1'b0);
    idle_count_busy(12, cnt);
    check("div_busy_cycles", cnt, 32'd10);
    step(MD_NONE, 32'd0, 32'd0, RD_LO, 1'b0, 1'b0);
    check("div_lo", md_out, 32'hFFFF_FFFD);
    step(MD_NONE, 32'd0, 32'd0, RD_HI, 1'b0, 1'b0);
    check("div_hi", md_out, 32'hFFFF_FFFF);

    // DIVU by zero leaves HI/LO alone
    step(MD_MTHI, 32'h0000_1234, 32'd0, RD_NONE, 1'b0, 1'b0);
    step(MD_MTLO, 32'h0000_5678, 32'd0, RD_NONE, 1'b0, 1'b0);
    step(MD_DIVU, 32'd7, 32'd0, RD_NONE, 1'b0, 1'b0);
    idle_count_busy(12, cnt);
    check("div0_busy_cycles", cnt, 32'd10);
    step(MD_NONE, 32'd0, 32'd0, RD_HI, 1'b0, 1'b0);
    check("div0_hi", md_out, 32'h0000_1234);
    step(MD_NONE, 32'd0, 32'd0, RD_LO, 1'b0, 1'b0);
    check("div0_lo", md_out, 32'h0000_5678);

    // MULT with mflo waiting in D
    step(MD_MULT, 32'd3, 32'hFFFF_FFFC, RD_NONE, 1'b1, 1'b0);
    cnt = stall_md ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      step(MD_NONE, 32'd0, 32'd0, RD_NONE, 1'b1, 1'b0);
      if (!stall_md) break;
      cnt++;
    end
    check("stall_cycles", cnt, 32'd6);
    step(MD_NONE, 32'd0, 32'd0, RD_LO, 1'b0, 1'b0);
    check("mflo_after_stall", md_out, 32'hFFFF_FFF4);

    // Reset during DIV discards the result
    step(MD_MTHI, 32'h0000_AAAA, 32'd0, RD_NONE, 1'b0, 1'b0);
    step(MD_MTLO, 32'h0000_BBBB, 32'd0, RD_NONE, 1'b0, 1'b0);
    step(MD_DIV, 32'd100, 32'd7, RD_NONE, 1'b0, 1'b0);
    step(MD_NONE, 32'd0, 32'd0, RD_NONE, 1'b0, 1'b0);
    step(MD_NONE, 32'd0, 32'd0, RD_NONE, 1'b0, 1'b0);
    step(MD_NONE, 32'd0, 32'd0, RD_NONE, 1'b0, 1'b1);
    step(MD_NONE, 32'd0, 32'd0, RD_HI, 1'b0, 1'b0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_hi", md_out, 32'd0);
    idle_count_busy(12, cnt);
    check("rst_no_busy", cnt, 32'd0);
    step(MD_NONE, 32'd0, 32'd0, RD_LO, 1'b0, 1'b0);
    check("rst_no_commit", md_out, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r  = $urandom_range(0, 99);
      rs = pick_operand();
      rt = pick_operand();
      if (m_active) begin
        if (r < 70)      op = MD_NONE;
        else if (r < 85) op = 4'($urandom_range(1, 4));
        else             op = 4'($urandom_range(7, 15));
      end else begin
        if (r < 35)      op = 4'($urandom_range(1, 4));
        else if (r < 45) op = 4'($urandom_range(5, 6));
        else if (r < 55) op = 4'($urandom_range(7, 15));
        else             op = MD_NONE;
      end
      if ((op == MD_DIV || op == MD_DIVU) && $urandom_range(0, 9) == 0) rt = 32'd0;
      step(op, rs, rt, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 199) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
